hht_csr_row_sequencer: RTL and testbench
========================================

// Module: hht_csr_row_sequencer
// PURPOSE
//  Sequences a CSR sparse-matrix x dense-vector walk for the HHT engine over two shared read ports.
//  Per row: reads row_ptr[r], row_ptr[r+1]; per nonzero: col_idx[k], val[k], then vec[col_idx[k]].
//  Hands {val, vec} pairs to the downstream MAC with a valid/ready handshake.
//  Sits between the HHT base-register file and the memory read ports.
// PARAMETERS
//  AW  32  address width
//  DW  32  data width (row_ptr, col_idx, val, vec)
// PORTS
//  Clk        in   1   clock, rising edge
//  Rst        in   1   synchronous, active-high reset
//  start      in   1   one-cycle pulse; sampled only in IDLE
//  num_rows   in   AW  rows to process; latched on start
//  row_base   in   AW  row_ptr array base; latched on start
//  col_base   in   AW  col_idx array base; latched on start
//  val_base   in   AW  value array base; latched on start
//  vec_base   in   AW  dense vector base; latched on start
//  addr1      out  AW  port-1 read address (row_ptr, col_idx)
//  dataIn1    in   DW  port-1 read data, valid combinationally for current addr1
//  addr2      out  AW  port-2 read address (val, vec)
//  dataIn2    in   DW  port-2 read data, valid combinationally for current addr2
//  mac_valid  out  1   mac_a/mac_b/mac_last/row_idx valid
//  mac_ready  in   1   MAC accepts when mac_valid & mac_ready
//  mac_a      out  DW  matrix value
//  mac_b      out  DW  vector element
//  mac_last   out  1   final pair of the current row
//  row_idx    out  AW  row the pair belongs to
//  busy       out  1   high from the cycle after start until done
//  done       out  1   one-cycle pulse after last row is emitted
//  err        out  1   sticky: row_ptr[r+1] < row_ptr[r]; cleared on start
// BEHAVIOUR
//  Reset: state IDLE; every output 0, including addr1/addr2 and err.
//  Addresses are registered. Data is sampled at the edge ending the cycle the address is held.
//  Each memory access costs exactly 1 cycle.
//  FSM:
//   IDLE  --start & num_rows==0--> DONE
//   IDLE  --start-->               RP0
//   RP0   addr1=row_base; latch kbeg.                                  -> RP1
//   RP1   addr1=row_base+r+1; latch kend.
//         kend<=kbeg: EMPTY (set err if kend<kbeg).  Else COL, k=kbeg.
//   COL   addr1=col_base+k, addr2=val_base+k; latch col, mac_a.        -> VEC
//   VEC   addr2=vec_base+col; latch mac_b.                             -> EMIT
//   EMIT  mac_valid=1, mac_last=(k==kend-1). Hold all outputs until mac_ready.
//         On accept: k+1<kend -> COL (k++). Else NEXT.
//   EMPTY emit one pair mac_a=0, mac_b=0, mac_last=1 (every row yields exactly one last). On accept -> NEXT.
//   NEXT  r++; kbeg=kend (row_ptr[r+1] reused, not re-read). r==num_rows -> DONE, else RP1.
//   DONE  done=1 for one cycle, busy=0                                 -> IDLE
//  Timing: first row costs 2 cycles (RP0, RP1); each later row costs 1 (RP1). NEXT is 1 cycle.
//  Per nonzero: 3 cycles minimum (COL, VEC, EMIT with mac_ready=1).
//  Arithmetic: all address sums modulo 2^AW, no saturation. k, r are AW bits.
//  start while busy: ignored; latched bases unaffected.
//  Rst mid-operation: IDLE on the next edge; mac_valid drops; no done pulse.
//  mac_ready while mac_valid=0: ignored.
//  No new address is issued while EMIT stalls.
// TESTING
//  1. Reset hold, then release -> all outputs 0, state IDLE; start with num_rows=0 -> done exactly 2 cycles after start, no mac_valid.
//  2. num_rows=1, row_base=25940 (row_ptr 0,2), col={3,0}, val={45,66}, vec[3]=87, vec[0]=8, mac_ready=1
//     -> pairs (45,87,last=0), (66,8,last=1), row_idx=0; done.
//  3. row_ptr={0,0,1}, num_rows=2 -> row 0 emits (0,0,last=1); row 1 emits one real pair, last=1; err stays 0.
//  4. Case 2 with mac_ready low 5 cycles on first pair -> outputs and addresses stable; pair count unchanged; done delayed 5 cycles.
//  5. row_ptr={5,3}: -> err=1, one empty pair; next start clears err.
//  6. Rst asserted during VEC of row 1 -> IDLE next edge; outputs 0; no done. New start re-runs from row 0 correctly.

Source files
------------

// File: rtl/hht_csr_row_sequencer.sv
// hht_csr_row_sequencer: walks a CSR matrix row by row over two read ports and
// streams {val, vec[col]} pairs to a MAC with a valid/ready handshake.
module hht_csr_row_sequencer #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          start,
    input  logic [AW-1:0] num_rows,
    input  logic [AW-1:0] row_base,
    input  logic [AW-1:0] col_base,
    input  logic [AW-1:0] val_base,
    input  logic [AW-1:0] vec_base,
    output logic [AW-1:0] addr1,
    input  logic [DW-1:0] dataIn1,
    output logic [AW-1:0] addr2,
    input  logic [DW-1:0] dataIn2,
    output logic          mac_valid,
    input  logic          mac_ready,
    output logic [DW-1:0] mac_a,
    output logic [DW-1:0] mac_b,
    output logic          mac_last,
    output logic [AW-1:0] row_idx,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] RP0   = 4'd1;
    localparam logic [3:0] RP1   = 4'd2;
    localparam logic [3:0] COL   = 4'd3;
    localparam logic [3:0] VEC   = 4'd4;
    localparam logic [3:0] EMIT  = 4'd5;
    localparam logic [3:0] EMPTY = 4'd6;
    localparam logic [3:0] NEXT  = 4'd7;
    localparam logic [3:0] DONE  = 4'd8;

    logic [3:0]    state_q, state_d;
    logic [AW-1:0] nrows_q, nrows_d, rbase_q, rbase_d, cbase_q, cbase_d;
    logic [AW-1:0] vbase_q, vbase_d, xbase_q, xbase_d;
    logic [AW-1:0] r_q, r_d, k_q, k_d, kbeg_q, kbeg_d, kend_q, kend_d;
    logic [AW-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic          err_q, err_d, done_q, done_d;
    logic [AW-1:0] d1, r1, k1;

    assign d1 = AW'(dataIn1);
    assign r1 = r_q + AW'(1);
    assign k1 = k_q + AW'(1);

    always_comb begin
        state_d = state_q;
        nrows_d = nrows_q;
        rbase_d = rbase_q;
        cbase_d = cbase_q;
        vbase_d = vbase_q;
        xbase_d = xbase_q;
        r_d     = r_q;
        k_d     = k_q;
        kbeg_d  = kbeg_q;
        kend_d  = kend_q;
        addr1_d = addr1_q;
        addr2_d = addr2_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        done_d  = state_q == DONE;
        case (state_q)
            IDLE: if (start) begin
                nrows_d = num_rows;
                rbase_d = row_base;
                cbase_d = col_base;
                vbase_d = val_base;
                xbase_d = vec_base;
                r_d     = '0;
                err_d   = 1'b0;
                state_d = num_rows == '0 ? DONE : RP0;
                addr1_d = num_rows == '0 ? addr1_q : row_base;
            end
            RP0: begin
                kbeg_d  = d1;
                addr1_d = rbase_q + r1;
                state_d = RP1;
            end
            RP1: begin
                kend_d = d1;
                if (d1 <= kbeg_q) begin
                    err_d   = err_q | (d1 < kbeg_q);
                    a_d     = '0;
                    b_d     = '0;
                    state_d = EMPTY;
                end else begin
                    k_d     = kbeg_q;
                    addr1_d = cbase_q + kbeg_q;
                    addr2_d = vbase_q + kbeg_q;
                    state_d = COL;
                end
            end
            COL: begin
                a_d     = dataIn2;
                addr2_d = xbase_q + d1;
                state_d = VEC;
            end
            VEC: begin
                b_d     = dataIn2;
                state_d = EMIT;
            end
            EMIT: if (mac_ready) begin
                if (k1 < kend_q) begin
                    k_d     = k1;
                    addr1_d = cbase_q + k1;
                    addr2_d = vbase_q + k1;
                    state_d = COL;
                end else begin
                    state_d = NEXT;
                end
            end
            EMPTY: state_d = mac_ready ? NEXT : EMPTY;
            NEXT: begin
                r_d     = r1;
                kbeg_d  = kend_q;
                addr1_d = r1 == nrows_q ? addr1_q : rbase_q + r1 + AW'(1);
                state_d = r1 == nrows_q ? DONE : RP1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            nrows_q <= '0;
            rbase_q <= '0;
            cbase_q <= '0;
            vbase_q <= '0;
            xbase_q <= '0;
            r_q     <= '0;
            k_q     <= '0;
            kbeg_q  <= '0;
            kend_q  <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nrows_q <= nrows_d;
            rbase_q <= rbase_d;
            cbase_q <= cbase_d;
            vbase_q <= vbase_d;
            xbase_q <= xbase_d;
            r_q     <= r_d;
            k_q     <= k_d;
            kbeg_q  <= kbeg_d;
            kend_q  <= kend_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign addr1     = addr1_q;
    assign addr2     = addr2_q;
    assign mac_valid = state_q == EMIT || state_q == EMPTY;
    assign mac_a     = a_q;
    assign mac_b     = b_q;
    assign mac_last  = state_q == EMPTY || (state_q == EMIT && k1 == kend_q);
    assign row_idx   = r_q;
    assign busy      = state_q != IDLE && state_q != DONE;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_hht_csr_row_sequencer.sv
// tb_hht_csr_row_sequencer: randomized scoreboard bench with a row-level CSR reference model.
module tb_hht_csr_row_sequencer;
    logic        Clk = 0, Rst = 1, start = 0, mac_ready = 1;
    logic [31:0] num_rows = 0, row_base = 0, col_base = 0, val_base = 0, vec_base = 0;
    logic [31:0] addr1, addr2, dataIn1, dataIn2, mac_a, mac_b, row_idx;
    logic        mac_valid, mac_last, busy, done, err;
    logic [31:0] mem [0:4095];

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        last;
        logic [31:0] row;
    } pair_t;

    pair_t exp_q[$];
    int    tests = 0, fails = 0, done_cnt = 0, ready_mode = 0, stall_cnt = 0;

    hht_csr_row_sequencer #(.AW(32), .DW(32)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .num_rows(num_rows),
        .row_base(row_base), .col_base(col_base), .val_base(val_base), .vec_base(vec_base),
        .addr1(addr1), .dataIn1(dataIn1), .addr2(addr2), .dataIn2(dataIn2),
        .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_a(mac_a), .mac_b(mac_b),
        .mac_last(mac_last), .row_idx(row_idx), .busy(busy), .done(done), .err(err)
    );

    assign dataIn1 = mem[addr1[11:0]];
    assign dataIn2 = mem[addr2[11:0]];

    always #5 Clk = ~Clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem[a[11:0]];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives mac_ready just after each rising edge according to the selected mode.
    initial forever begin
        @(posedge Clk);
        #1;
        if (ready_mode == 0) mac_ready = 1;
        else if (ready_mode == 1) mac_ready = $urandom_range(0, 3) != 0;
        else if (mac_valid && stall_cnt < 5) begin
            mac_ready = 0;
            stall_cnt++;
        end else mac_ready = 1;
    end

    // Monitor: pops expected pairs on every handshake, and checks hold-stability during stalls.
    initial begin
        logic        stalled;
        logic [31:0] s_a, s_b, s_row, s_a1, s_a2;
        logic        s_last;
        pair_t       e;
        stalled = 0;
        forever begin
            @(negedge Clk);
            if (done) done_cnt++;
            if (stalled) begin
                chk("stall_valid", mac_valid, 1);
                chk("stall_out", {mac_a, mac_b}, {s_a, s_b});
                chk("stall_meta", {31'b0, mac_last, row_idx}, {31'b0, s_last, s_row});
                chk("stall_addr", {addr1, addr2}, {s_a1, s_a2});
            end
            stalled = mac_valid && !mac_ready && !Rst;
            {s_a, s_b, s_last, s_row, s_a1, s_a2} = {mac_a, mac_b, mac_last, row_idx, addr1, addr2};
            if (mac_valid && mac_ready && !Rst) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pair: got a=%0h b=%0h row=%0d, expected none", mac_a, mac_b, row_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("pair_a", mac_a, e.a);
                    chk("pair_b", mac_b, e.b);
                    chk("pair_last", mac_last, e.last);
                    chk("pair_row", row_idx, e.row);
                end
            end
        end
    end

    // Reference: every row yields its nonzeros (or one zero pair if empty), the last one flagged.
    task automatic model(input int n, input logic [31:0] rb, cb, vb, xb, output logic exp_err, output int cyc);
        logic [31:0] b, e, c;
        exp_err = 0;
        cyc = n > 0 ? 2 : 1;
        for (int r = 0; r < n; r++) begin
            b = rd(rb + r);
            e = rd(rb + r + 1);
            if (e <= b) begin
                exp_q.push_back('{a: 0, b: 0, last: 1, row: r});
                exp_err |= e < b;
                cyc += 3;
            end else begin
                for (logic [31:0] k = b; k < e; k++) begin
                    c = rd(cb + k);
                    exp_q.push_back('{a: rd(vb + k), b: rd(xb + c), last: k == e - 1, row: r});
                end
                cyc += 2 + 3 * int'(e - b);
            end
        end
    endtask

    task automatic run_job(input int n, input logic [31:0] rb, cb, vb, xb, input int mode);
        logic exp_err;
        int   exp_cyc, cycles;
        model(n, rb, cb, vb, xb, exp_err, exp_cyc);
        ready_mode = mode;
        stall_cnt = 0;
        @(posedge Clk);
        #1;
        {num_rows, row_base, col_base, val_base, vec_base} = {n, rb, cb, vb, xb};
        start = 1;
        @(posedge Clk);
        #1;
        start = 0;
        if (n != 0) chk("busy_after_start", busy, 1);
        chk("err_cleared", err, 0);
        cycles = 0;
        while (!done && cycles < 5000) begin
            @(posedge Clk);
            #1;
            cycles++;
            start = n != 0 && cycles == 3;
            if (start) {num_rows, row_base, col_base} = {32'd7, 32'd0, 32'd0};
        end
        start = 0;
        chk("done_seen", done, 1);
        if (mode == 0) chk("cycles", cycles, exp_cyc);
        if (mode == 2) chk("cycles_stall", cycles, exp_cyc + 5);
        chk("pairs_left", exp_q.size(), 0);
        chk("err", err, exp_err);
        chk("busy_at_done", busy, 0);
        @(posedge Clk);
        #1;
        chk("done_pulse", done, 0);
        exp_q.delete();
    endtask

    task automatic setup_case2();
        mem[1364] = 0;  mem[1365] = 2;
        mem[512]  = 3;  mem[513]  = 0;
        mem[2048] = 45; mem[2049] = 66;
        mem[3072 + 3] = 87; mem[3072] = 8;
    endtask

    initial begin
        int d0, n, p, hit;
        for (int i = 0; i < 4096; i++) mem[i] = i < 1024 && i >= 512 ? $urandom_range(0, 15) : $urandom;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_hold_out", {addr1, addr2, mac_a, mac_b, row_idx}, 0);
        chk("reset_hold_flags", {mac_valid, mac_last, busy, done, err}, 0);
        Rst = 0;
        @(posedge Clk);
        #1;
        chk("reset_rel_out", {addr1, addr2, mac_a, mac_b, row_idx}, 0);
        chk("reset_rel_flags", {mac_valid, mac_last, busy, done, err}, 0);
        run_job(0, 32'd100, 32'd512, 32'd2048, 32'd3072, 0);
        setup_case2();
        run_job(1, 32'd25940, 32'd512, 32'd2048, 32'd3072, 0);
        mem[10] = 0; mem[11] = 0; mem[12] = 1;
        mem[600] = 5; mem[2100] = 123; mem[3072 + 5] = 456;
        run_job(2, 32'd10, 32'd600, 32'd2100, 32'd3072, 0);
        setup_case2();
        run_job(1, 32'd25940, 32'd512, 32'd2048, 32'd3072, 2);
        mem[20] = 5; mem[21] = 3;
        run_job(1, 32'd20, 32'd512, 32'd2048, 32'd3072, 0);
        setup_case2();
        run_job(1, 32'd25940, 32'd512, 32'd2048, 32'd3072, 1);
        mem[30] = 0; mem[31] = 2; mem[32] = 3; mem[33] = 5;
        model(3, 32'd30, 32'd520, 32'd2200, 32'd3072, p[0], n);
        ready_mode = 0;
        @(posedge Clk);
        #1;
        {num_rows, row_base, col_base, val_base, vec_base} = {32'd3, 32'd30, 32'd520, 32'd2200, 32'd3072};
        start = 1;
        @(posedge Clk);
        #1;
        start = 0;
        hit = 0;
        for (int i = 0; i < 200 && hit == 0; i++) begin
            @(posedge Clk);
            #1;
            hit = int'(row_idx == 1 && !mac_valid && addr1[11:9] == 3'b001 && addr2[11:10] == 2'b11);
        end
        chk("vec_row1_reached", hit, 1);
        Rst = 1;
        @(posedge Clk);
        #1;
        chk("midreset_out", {addr1, addr2, mac_a, mac_b, row_idx}, 0);
        chk("midreset_flags", {mac_valid, mac_last, busy, done, err}, 0);
        Rst = 0;
        exp_q.delete();
        d0 = done_cnt;
        repeat (20) @(posedge Clk);
        #1;
        chk("no_done_after_reset", done_cnt, d0);
        run_job(3, 32'd30, 32'd520, 32'd2200, 32'd3072, 0);
        for (int j = 0; j < 20; j++) begin
            n = $urandom_range(1, 6);
            p = $urandom_range(0, 3);
            mem[40] = p;
            for (int r = 1; r <= n; r++) begin
                if ($urandom_range(0, 7) == 0 && p >= 2) p -= $urandom_range(1, 2);
                else p += $urandom_range(0, 3);
                mem[40 + r] = p;
            end
            run_job(n, 32'd40, 32'd512 + $urandom_range(0, 200), 32'd2048 + $urandom_range(0, 500),
                    32'd3072 + $urandom_range(0, 500), $urandom_range(0, 1));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
